// File: rtl/count_nbit_mod_pkg.sv
// Shared constants, action encoding and parameter checks for the modulus counter.
// Pure declarations; no timing and no flow control.
package count_nbit_mod_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   typedef enum logic [2:0] {
      ACT_HOLD    = 3'd0,
      ACT_LOAD    = 3'd1,
      ACT_INC     = 3'd2,
      ACT_DEC     = 3'd3,
      ACT_WRAP_UP = 3'd4,
      ACT_WRAP_DN = 3'd5
   } cnt_action_e;

   function automatic bit cnt_params_ok(input int width, input longint modulus);
      return (width >= 1) && (width <= 31) &&
             (modulus >= 2) && (modulus <= (64'sd1 <<< width));
   endfunction

   // The binary carry chain only matches modulo behaviour when every code is used.
   function automatic bit cnt_full_range(input int width, input longint modulus);
      return modulus == (64'sd1 <<< width);
   endfunction

endpackage

// File: rtl/count_nbit_mod_tff_cell.sv
// One counter bit: toggles on a rising edge when i_t is high; updates one edge after i_t.
// Asynchronous active-high clear; no flow control.
module tff_cell (
   input  logic i_clock,
   input  logic i_clear,
   input  logic i_t,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_q <= 1'b0;
      end else if (i_t) begin
         r_q <= ~r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/count_nbit_mod.sv
// Up/down modulo counter with load, wrap/saturate and cascadable terminal count, built from T cells.
// Q and wrap update one edge after sampling; TC is combinational; no backpressure.
module count_nbit_mod
   import count_nbit_mod_pkg::*;
#(
   parameter int     WIDTH    = 16,
   parameter longint MODULUS  = 65536,
   parameter int     SATURATE = 0
) (
   input  logic             i_clock,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic             i_up,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic             o_tc,
   output logic             o_wrap
);

   if (!cnt_params_ok(WIDTH, MODULUS)) begin : g_param_check
      $error("count_nbit_mod: need 1 <= WIDTH <= 31 and 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
   localparam bit               FULL_RANGE = cnt_full_range(WIDTH, MODULUS);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_load_val;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_at_term;
   logic             w_wrap_next;
   cnt_action_e      w_action;
   logic             r_wrap;

   assign w_at_max   = (w_q == MAX_VAL);
   assign w_at_zero  = (w_q == '0);
   assign w_at_term  = (i_up == CNT_UP) ? w_at_max : w_at_zero;
   assign w_load_val = ({1'b0, i_d} < MOD_EXT) ? i_d : MAX_VAL;

   always_comb begin
      w_action = ACT_HOLD;
      if (i_load) begin
         w_action = ACT_LOAD;
      end else if (i_enable) begin
         if (!w_at_term) begin
            w_action = (i_up == CNT_UP) ? ACT_INC : ACT_DEC;
         end else if (SATURATE == CNT_SAT) begin
            w_action = ACT_HOLD;
         end else begin
            w_action = (i_up == CNT_UP) ? ACT_WRAP_UP : ACT_WRAP_DN;
         end
      end
   end

   assign w_wrap_next = (w_action == ACT_WRAP_UP) || (w_action == ACT_WRAP_DN);

   if (FULL_RANGE) begin : g_carry_chain
      // Natural binary rollover: all-ones chain gives the wrap for free.
      logic [WIDTH-1:0] w_chain_up;
      logic [WIDTH-1:0] w_chain_dn;

      assign w_chain_up[0] = 1'b1;
      assign w_chain_dn[0] = 1'b1;
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign w_chain_up[gi] = w_chain_up[gi-1] &  w_q[gi-1];
         assign w_chain_dn[gi] = w_chain_dn[gi-1] & ~w_q[gi-1];
      end

      always_comb begin
         w_t = '0;
         case (w_action)
            ACT_LOAD:             w_t = w_load_val ^ w_q;
            ACT_INC, ACT_WRAP_UP: w_t = w_chain_up;
            ACT_DEC, ACT_WRAP_DN: w_t = w_chain_dn;
            default:              w_t = '0;
         endcase
      end
   end else begin : g_modulo
      logic [WIDTH-1:0] w_q_next;

      always_comb begin
         w_q_next = w_q;
         case (w_action)
            ACT_LOAD:    w_q_next = w_load_val;
            ACT_INC:     w_q_next = w_q + 1'b1;
            ACT_DEC:     w_q_next = w_q - 1'b1;
            ACT_WRAP_UP: w_q_next = '0;
            ACT_WRAP_DN: w_q_next = MAX_VAL;
            default:     w_q_next = w_q;
         endcase
      end

      assign w_t = w_q_next ^ w_q;
   end

   for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
      tff_cell u_cell (
         .i_clock (i_clock),
         .i_clear (i_clear),
         .i_t     (w_t[gb]),
         .o_q     (w_q[gb])
      );
   end

   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_next;
      end
   end

   assign o_q    = w_q;
   assign o_tc   = i_enable & ~i_load & w_at_term;
   assign o_wrap = r_wrap;

endmodule

// File: tb/tb_count_nbit_mod.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor compares them.
module tb_count_nbit_mod;

   typedef struct {
      int     id;
      longint q;
      bit     wrap;
      bit     tc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_c;
   logic        en_s [5];
   logic        up_s [5];
   logic        ld_s [5];
   logic [15:0] d_s  [5];

   logic [3:0]  q_a, q_b, q_e1, q_e2;
   logic [15:0] q_c;
   logic        tc_a, tc_b, tc_c, tc_e1, tc_e2;
   logic        wrap_a, wrap_b, wrap_c, wrap_e1, wrap_e2;

   exp_t   sb_q[$];
   longint m_q    [5];
   bit     m_wrap [5];
   longint m_mod  [5] = '{10, 10, 65536, 10, 10};
   bit     m_sat  [5] = '{0, 1, 0, 0, 0};
   int     n_checks = 0;
   int     n_errors = 0;

   always #5 clk = ~clk;

   count_nbit_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
      .i_clock(clk), .i_clear(rst), .i_enable(en_s[0]), .i_up(up_s[0]), .i_load(ld_s[0]),
      .i_d(d_s[0][3:0]), .o_q(q_a), .o_tc(tc_a), .o_wrap(wrap_a));

   count_nbit_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
      .i_clock(clk), .i_clear(rst), .i_enable(en_s[1]), .i_up(up_s[1]), .i_load(ld_s[1]),
      .i_d(d_s[1][3:0]), .o_q(q_b), .o_tc(tc_b), .o_wrap(wrap_b));

   count_nbit_mod u_c (
      .i_clock(clk), .i_clear(rst | clr_c), .i_enable(en_s[2]), .i_up(up_s[2]), .i_load(ld_s[2]),
      .i_d(d_s[2]), .o_q(q_c), .o_tc(tc_c), .o_wrap(wrap_c));

   count_nbit_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_e1 (
      .i_clock(clk), .i_clear(rst), .i_enable(en_s[3]), .i_up(up_s[3]), .i_load(ld_s[3]),
      .i_d(d_s[3][3:0]), .o_q(q_e1), .o_tc(tc_e1), .o_wrap(wrap_e1));

   count_nbit_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_e2 (
      .i_clock(clk), .i_clear(rst), .i_enable(tc_e1), .i_up(up_s[4]), .i_load(ld_s[4]),
      .i_d(d_s[4][3:0]), .o_q(q_e2), .o_tc(tc_e2), .o_wrap(wrap_e2));

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint get_q(input int id);
      case (id)
         0: return longint'(q_a);
         1: return longint'(q_b);
         2: return longint'(q_c);
         3: return longint'(q_e1);
         default: return longint'(q_e2);
      endcase
   endfunction

   function automatic bit get_wrap(input int id);
      case (id)
         0: return wrap_a;
         1: return wrap_b;
         2: return wrap_c;
         3: return wrap_e1;
         default: return wrap_e2;
      endcase
   endfunction

   function automatic bit get_tc(input int id);
      case (id)
         0: return tc_a;
         1: return tc_b;
         2: return tc_c;
         3: return tc_e1;
         default: return tc_e2;
      endcase
   endfunction

   function automatic longint d_val(input int id);
      return (id == 2) ? longint'(d_s[2]) : longint'(d_s[id][3:0]);
   endfunction

   // Stage 2 of the cascade is enabled by the terminal count of stage 1.
   function automatic bit model_en(input int id);
      if (id == 4) return model_tc(3);
      return en_s[id];
   endfunction

   function automatic bit model_tc(input int id);
      longint term;
      term = up_s[id] ? m_mod[id] - 1 : 0;
      return model_en(id) && !ld_s[id] && (m_q[id] == term);
   endfunction

   task automatic model_next(input int id, output longint nq, output bit nw);
      longint q, d;
      q  = m_q[id];
      d  = d_val(id);
      nq = q;
      nw = 1'b0;
      if (ld_s[id]) begin
         nq = (d < m_mod[id]) ? d : m_mod[id] - 1;
      end else if (model_en(id)) begin
         if (up_s[id]) begin
            if (q + 1 < m_mod[id]) nq = q + 1;
            else if (!m_sat[id]) begin nq = 0; nw = 1'b1; end
         end else begin
            if (q > 0) nq = q - 1;
            else if (!m_sat[id]) begin nq = m_mod[id] - 1; nw = 1'b1; end
         end
      end
   endtask

   task automatic tick();
      longint nq [5];
      bit     nw [5];
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         e.id   = i;
         e.q    = m_q[i];
         e.wrap = m_wrap[i];
         e.tc   = model_tc(i);
         sb_q.push_back(e);
         model_next(i, nq[i], nw[i]);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         m_q[i]    = nq[i];
         m_wrap[i] = nw[i];
      end
   endtask

   task automatic set_in(input int id, input bit en, input bit up, input bit ld, input logic [15:0] d);
      en_s[id] = en;
      up_s[id] = up;
      ld_s[id] = ld;
      d_s[id]  = d;
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check($sformatf("sb_q[%0d]", e.id),    get_q(e.id),    e.q);
         check($sformatf("sb_wrap[%0d]", e.id), get_wrap(e.id), e.wrap);
         check($sformatf("sb_tc[%0d]", e.id),   get_tc(e.id),   e.tc);
      end
   end

   initial begin
      rst   = 1'b1;
      clr_c = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(i, 1'b0, 1'b1, 1'b0, 16'd0);
         m_q[i]    = 0;
         m_wrap[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #2;
      check("reset_q_a", q_a, 0);
      check("reset_wrap_a", wrap_a, 0);
      check("reset_q_c", q_c, 0);
      check("reset_q_e2", q_e2, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Count up from reset on both the wrapping and saturating 0..9 counters.
      set_in(0, 1'b1, 1'b1, 1'b0, 16'd0);
      set_in(1, 1'b1, 1'b1, 1'b0, 16'd0);
      repeat (12) tick();
      check("up12_q_a", q_a, 2);
      check("sat_hold_q_b", q_b, 9);

      set_in(0, 1'b0, 1'b1, 1'b0, 16'd0);
      set_in(1, 1'b1, 1'b0, 1'b0, 16'd0);
      tick();
      check("sat_down_q_b", q_b, 8);

      set_in(1, 1'b0, 1'b1, 1'b0, 16'd0);
      set_in(0, 1'b0, 1'b1, 1'b1, 16'd0);
      tick();
      set_in(0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick();
      check("down_wrap_q_a", q_a, 9);
      check("down_wrap_pulse_a", wrap_a, 1);
      repeat (2) tick();
      check("down3_q_a", q_a, 7);

      set_in(0, 1'b1, 1'b1, 1'b1, 16'd13);
      tick();
      check("load_clamp_q_a", q_a, 9);
      set_in(0, 1'b1, 1'b1, 1'b1, 16'd5);
      tick();
      check("load_q_a", q_a, 5);
      set_in(0, 1'b0, 1'b1, 1'b0, 16'd0);

      // Asynchronous clear between edges on the 16-bit counter.
      set_in(2, 1'b0, 1'b1, 1'b1, 16'h1234);
      tick();
      check("load_q_c", q_c, 'h1234);
      set_in(2, 1'b0, 1'b1, 1'b0, 16'd0);
      #1 clr_c = 1'b1;
      #1;
      check("async_clear_q_c", q_c, 0);
      clr_c     = 1'b0;
      m_q[2]    = 0;
      m_wrap[2] = 1'b0;
      tick();
      set_in(2, 1'b0, 1'b1, 1'b1, 16'hFFFE);
      tick();
      set_in(2, 1'b1, 1'b1, 1'b0, 16'd0);
      repeat (2) tick();
      check("rollover_q_c", q_c, 0);
      check("rollover_wrap_c", wrap_c, 1);
      set_in(2, 1'b0, 1'b1, 1'b0, 16'd0);

      // Two-digit decimal cascade.
      set_in(3, 1'b1, 1'b1, 1'b0, 16'd0);
      set_in(4, 1'b0, 1'b1, 1'b0, 16'd0);
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (n == 57) begin
            check("cascade57_hi", q_e2, 5);
            check("cascade57_lo", q_e1, 7);
         end
      end
      check("cascade100_hi", q_e2, 0);
      check("cascade100_lo", q_e1, 0);
      check("cascade100_wrap", wrap_e2, 1);

      // Randomized traffic, biased toward the load and boundary values.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            logic [15:0] d;
            d = (i == 2) ? 16'($urandom) : 16'($urandom_range(0, 15));
            if (i == 2 && $urandom_range(0, 3) == 0)
               d = ($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                                 : 16'($urandom_range(0, 2));
            set_in(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 15) == 0, d);
         end
         set_in(3, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 31) == 0, 16'($urandom_range(0, 15)));
         set_in(4, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 16'd0);
         tick();
      end

      for (int i = 0; i < 5; i++) set_in(i, 1'b0, 1'b1, 1'b0, 16'd0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
